// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits answer combinationally; misses and stores stall the pipeline
// while a single-beat request runs against the backing memory.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] addr,
  input  logic [63:0] wd,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  output logic [63:0] rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 61 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_store [LINES];
  logic [63:0]        data_store [LINES];
  logic [63:0]        resp_data;

  // In IDLE the lookup uses the live MEM-stage address; during a transaction
  // it uses the latched request address so the line touched is the one requested.
  logic [60:0]        look;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               is_write;
  logic               is_read;
  logic               unused_ok;

  assign look      = (state == IDLE) ? addr[63:3] : mem_addr[63:3];
  assign idx       = look[IDX_W-1:0];
  assign tag       = look[60:IDX_W];
  assign hit       = valid[idx] && (tag_store[idx] == tag);
  assign is_write  = memwrite_mem;
  assign is_read   = memread_mem && !memwrite_mem;
  assign unused_ok = ^{addr[2:0], mem_addr[2:0]};

  // Next-state, stall and load-data decode; reset forces stall and rd low.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    rd         = '0;
    case (state)
      IDLE: begin
        if (is_write) begin
          stall      = 1'b1;
          state_next = WRITE;
        end else if (is_read) begin
          if (hit) begin
            rd = data_store[idx];
          end else begin
            stall      = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL, WRITE: begin
        stall = 1'b1;
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        rd         = resp_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rstn) begin
      stall = 1'b0;
      rd    = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Registered memory request, valid bits, response data and counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[63:3], 3'b000};
            mem_wdata <= wd;
          end else if (is_read) begin
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {addr[63:3], 3'b000};
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid[idx] <= 1'b1;
            resp_data  <= mem_rdata;
            mem_req    <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            resp_data <= '0;
            mem_req   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rstn && mem_ready) begin
      if (state == FILL) begin
        tag_store[idx]  <= tag;
        data_store[idx] <= mem_rdata;
      end else if (state == WRITE && hit) begin
        data_store[idx] <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// accesses, all checked against a line-level cache and backing-memory model.
module tb_dcache_ctrl;

  localparam int LINES = 16;
  localparam int IDX_W = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] addr;
  logic [63:0] wd;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [63:0] rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_ctrl #(.LINES(LINES)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .wd(wd),
    .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
    .rd(rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache lines, backing memory and counters.
  logic        m_valid [LINES];
  logic [63:0] m_tag   [LINES];
  logic [63:0] m_data  [LINES];
  logic [63:0] bmem    [logic [63:0]];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; memread_mem = 1'b0; memwrite_mem = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_rd", rd, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hits", hit_cnt, 0);
    check("rst_misses", miss_cnt, 0);
    rstn = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  // One pipeline access, entered and left at posedge+1.
  task automatic access(input logic [63:0] a, input logic [63:0] d,
                        input logic r, input logic w, input int lat);
    logic [63:0] a_al, tg, rdata;
    int idx;
    bit is_r, is_w, m_hit;
    a_al  = {a[63:3], 3'b000};
    idx   = int'((a_al >> 3) % LINES);
    tg    = a_al >> (3 + IDX_W);
    is_w  = w;
    is_r  = r && !w;
    m_hit = m_valid[idx] && (m_tag[idx] == tg);
    addr = a; wd = d; memread_mem = r; memwrite_mem = w;
    $display("txn addr=%h wd=%h rd_en=%0b wr_en=%0b lat=%0d model_hit=%0b", a, d, r, w, lat, m_hit);
    @(negedge clk);
    if (!is_r && !is_w) begin
      check("idle_stall", stall, 0);
      check("idle_rd", rd, 0);
      @(posedge clk); #1;
      return;
    end
    if (is_r && m_hit) begin
      check("hit_stall", stall, 0);
      check("hit_rd", rd, m_data[idx]);
      check("hit_noreq", mem_req, 0);
      @(posedge clk); #1;
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
      check("hit_cnt", hit_cnt, m_hits);
      check("hit_miss_cnt", miss_cnt, m_misses);
      return;
    end
    check("detect_stall", stall, 1);
    if (is_r && m_misses != 32'hFFFF_FFFF) m_misses++;
    @(posedge clk); #1;
    if (is_r) rdata = bmem.exists(a_al) ? bmem[a_al] : {$urandom, $urandom};
    else begin
      rdata = '0;
      bmem[a_al] = d;
    end
    for (int i = 0; i < lat; i++) begin
      mem_ready = (i == lat - 1);
      mem_rdata = (i == lat - 1) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      check("busy_stall", stall, 1);
      check("busy_req", mem_req, 1);
      check("busy_we", mem_we, is_w);
      check("busy_maddr", mem_addr, a_al);
      if (is_w) check("busy_wdata", mem_wdata, d);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (is_r) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = rdata;
    end else if (m_hit) begin
      m_data[idx] = d;
    end
    @(negedge clk);
    check("resp_stall", stall, 0);
    check("resp_req", mem_req, 0);
    check("resp_rd", rd, is_r ? rdata : 64'd0);
    check("resp_hits", hit_cnt, m_hits);
    check("resp_misses", miss_cnt, m_misses);
    @(posedge clk); #1;
    memread_mem = 1'b0; memwrite_mem = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    int op;
    addr = '0; wd = '0; mem_rdata = '0;
    do_reset();

    // Cold read, then repeat hit.
    bmem[64'h100] = 64'hDEAD_BEEF;
    access(64'h100, 0, 1, 0, 1);
    access(64'h100, 0, 1, 0, 1);

    // Conflict on index 0: 0x180 evicts 0x100, which then misses again.
    access(64'h180, 0, 1, 0, 2);
    access(64'h100, 0, 1, 0, 1);
    check("conflict_misses", miss_cnt, 3);

    // Write-through hit with slow memory, then read back.
    access(64'h100, 64'h1234, 0, 1, 3);
    access(64'h100, 0, 1, 0, 1);
    check("wt_readback", m_data[0], 64'h1234);

    // No-allocate write on a cold cache; later read misses.
    do_reset();
    access(64'h200, 64'h55, 0, 1, 1);
    access(64'h200, 0, 1, 0, 2);
    check("noalloc_misses", miss_cnt, 1);

    // Reset while in FILL; late mem_ready must be ignored.
    addr = 64'h300; memread_mem = 1'b1; memwrite_mem = 1'b0;
    @(negedge clk);
    check("mid_detect", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_fill_req", mem_req, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_rd", rd, 0);
    @(posedge clk); #1;
    rstn = 1'b1; memread_mem = 1'b0; mem_ready = 1'b1; mem_rdata = 64'hBAD0_BAD0;
    @(negedge clk);
    check("mid_req", mem_req, 0);
    check("mid_stall", stall, 0);
    check("mid_misses", miss_cnt, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("mid_late_ready", mem_req, 0);
    @(posedge clk); #1;
    model_clear();
    access(64'h200, 0, 1, 0, 1);
    access(64'h300, 0, 1, 0, 1);

    // Both strobes: treated as a write.
    access(64'h300, 64'hCAFE, 1, 1, 2);
    access(64'h300, 0, 1, 0, 1);

    // Random mix over a small address window to force conflicts.
    for (int n = 0; n < 80; n++) begin
      ra = (64'($urandom_range(0, 3)) << (3 + IDX_W)) |
           (64'($urandom_range(0, LINES - 1)) << 3) | 64'($urandom_range(0, 7));
      op = $urandom_range(0, 10);
      if (op <= 5)      access(ra, 0, 1, 0, $urandom_range(1, 4));
      else if (op <= 8) access(ra, {$urandom, $urandom}, 0, 1, $urandom_range(1, 4));
      else if (op == 9) access(ra, {$urandom, $urandom}, 1, 1, $urandom_range(1, 4));
      else              access(ra, 0, 0, 0, 1);
    end
    memread_mem = 1'b0; memwrite_mem = 1'b0;

    // Hit counter saturation.
    access(64'h300, 0, 1, 0, 1);
    force dut.hit_cnt = 32'hFFFF_FFFF;
    addr = 64'h300; memread_mem = 1'b1;
    @(negedge clk);
    check("sat_hit_rd", rd, 64'hCAFE);
    check("sat_hit_stall", stall, 0);
    @(posedge clk); #1;
    release dut.hit_cnt;
    memread_mem = 1'b0;
    @(negedge clk);
    check("sat_hits", hit_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    m_hits = 32'hFFFF_FFFF;
    access(64'h300, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
